// File: rtl/cim_seq_pkg.sv
// Shared definitions for the CIM host sequencer.
//   - seq_state_t : sequencer FSM states
//   - ERR_*       : bit positions inside the 2-bit res_err field
//   - slot_width  : number of phase bits that index cycles within one weight slot
package cim_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ALIGN,
        STREAM,
        WAIT_DONE,
        CAPTURE,
        RESULT
    } seq_state_t;

    localparam int ERR_W        = 2;
    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_TIMEOUT  = 1;

    // A throughput of 1 needs no sub-slot bits; every cycle starts a slot.
    function automatic int slot_width(input int thru);
        return $clog2(thru);
    endfunction

endpackage

// File: rtl/cim_phase_counter.sv
// Free-running phase counter that mirrors the CIM chip's internal counter.
// Both counters are cleared by the same reset and never stall, so they stay
// in lock step for the life of the system.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   all_ones    : counter is at its last value (next cycle is phase 0)
//   slot_start  : low SLOT_W bits are zero, i.e. a new weight slot begins
module cim_phase_counter #(
    parameter int CNT_W  = 3,
    parameter int SLOT_W = 0
) (
    input  logic clk,
    input  logic reset,
    output logic all_ones,
    output logic slot_start
);

    logic [CNT_W-1:0] phase_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    assign all_ones = &phase_reg;

    generate
        if (SLOT_W == 0) begin : g_single_cycle_slot
            assign slot_start = 1'b1;
        end else begin : g_multi_cycle_slot
            assign slot_start = (phase_reg[SLOT_W-1:0] == '0);
        end
    endgenerate

endmodule

// File: rtl/cim_host_sequencer.sv
// Host-side job sequencer for the CIM compute chip.
// A job (activation word + scale) is loaded into the chip, then
// STAGE_1_NUM_INPUTS weights are streamed phase-aligned to the chip's
// free-running counter, the chip's done strobe is awaited and the stage-4
// result is returned on a valid/ready channel together with error flags.
// Ports:
//   cmd_valid/cmd_ready/cmd_act/cmd_scale : job request (accepted in IDLE)
//   wt_valid/wt_ready/wt_data             : weight source (consumed in STREAM)
//   wrEn_act_array/wrData_act             : chip activation array write
//   wrEn_queue/wrData_queue               : chip scale queue write
//   input_wt                              : weight presented to the chip
//   done/stage_4_out                      : chip completion strobe and result
//   res_valid/res_ready/res_data/res_err  : result channel, res_err={timeout,underrun}
//   busy                                  : a job is in flight
// Build option: define CIM_SEQ_TIMEOUT_EN to abort WAIT_DONE after
// TIMEOUT_CYCLES cycles with res_data=0 and the timeout bit set.
module cim_host_sequencer
    import cim_seq_pkg::*;
#(
    parameter int STAGE_1_NUM_INPUTS    = 8,
    parameter int STAGE_1_BIT_WIDTH     = 8,
    parameter int SRAM_THROUGHPUT       = 1,
    parameter int STAGE_4_BIT_WIDTH     = 4,
    parameter int STAGE_4_OUT_BIT_WIDTH = (STAGE_1_NUM_INPUTS + STAGE_1_BIT_WIDTH - 1)
                                          + $clog2(STAGE_1_NUM_INPUTS) + STAGE_4_BIT_WIDTH,
    parameter int CNT_W                 = $clog2(SRAM_THROUGHPUT) + $clog2(STAGE_1_NUM_INPUTS),
    parameter int TIMEOUT_CYCLES        = 4 * STAGE_1_NUM_INPUTS * SRAM_THROUGHPUT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [STAGE_1_BIT_WIDTH-1:0]     cmd_act,
    input  logic [STAGE_4_BIT_WIDTH-1:0]     cmd_scale,
    input  logic                             wt_valid,
    output logic                             wt_ready,
    input  logic [STAGE_1_BIT_WIDTH-1:0]     wt_data,
    output logic                             wrEn_act_array,
    output logic [STAGE_1_BIT_WIDTH-1:0]     wrData_act,
    output logic                             wrEn_queue,
    output logic [STAGE_4_BIT_WIDTH-1:0]     wrData_queue,
    output logic [STAGE_1_BIT_WIDTH-1:0]     input_wt,
    input  logic                             done,
    input  logic [STAGE_4_OUT_BIT_WIDTH-1:0] stage_4_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [STAGE_4_OUT_BIT_WIDTH-1:0] res_data,
    output logic [ERR_W-1:0]                 res_err,
    output logic                             busy
);

    localparam int SLOT_W = slot_width(SRAM_THROUGHPUT);

    seq_state_t state_reg, state_next;

    logic [STAGE_1_BIT_WIDTH-1:0]     act_reg;
    logic [STAGE_4_BIT_WIDTH-1:0]     scale_reg;
    logic [STAGE_1_BIT_WIDTH-1:0]     wt_hold_reg;
    logic [STAGE_4_OUT_BIT_WIDTH-1:0] res_data_reg;
    logic                             underrun_reg;
    logic                             all_ones;
    logic                             slot_start;
    logic                             timeout_hit;
    logic                             timeout_flag;
    logic [STAGE_1_BIT_WIDTH-1:0]     slot_wt;

    cim_phase_counter #(
        .CNT_W  (CNT_W),
        .SLOT_W (SLOT_W)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .all_ones   (all_ones),
        .slot_start (slot_start)
    );

    // A missing weight at a slot start is presented as zero rather than stalling,
    // because the chip's counter keeps running regardless.
    assign slot_wt = wt_valid ? wt_data : '0;

`ifdef CIM_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;

    assign timeout_hit  = (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_reg == WAIT_DONE) ? wait_cnt_reg + 1'b1 : '0;
            if (state_reg == IDLE && cmd_valid) begin
                timeout_reg <= 1'b0;
            end else if (state_reg == WAIT_DONE && !done && timeout_hit) begin
                timeout_reg <= 1'b1;
            end else if (state_reg == RESULT && res_ready) begin
                timeout_reg <= 1'b0;
            end
        end
    end
`else
    // Without the timeout feature WAIT_DONE waits forever; this compare is
    // constant false for any legal (positive) TIMEOUT_CYCLES.
    assign timeout_hit  = (TIMEOUT_CYCLES < 0);
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_reg      <= '0;
            scale_reg    <= '0;
            wt_hold_reg  <= '0;
            res_data_reg <= '0;
            underrun_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && cmd_valid) begin
                act_reg      <= cmd_act;
                scale_reg    <= cmd_scale;
                underrun_reg <= 1'b0;
            end else if (state_reg == STREAM && slot_start && !wt_valid) begin
                underrun_reg <= 1'b1;
            end else if (state_reg == RESULT && res_ready) begin
                underrun_reg <= 1'b0;
            end

            if (state_reg == STREAM && slot_start) begin
                wt_hold_reg <= slot_wt;
            end

            // The chip updates its stage-4 register on the done edge, so the
            // settled value is only visible one cycle later, in CAPTURE.
            if (state_reg == CAPTURE) begin
                res_data_reg <= stage_4_out;
            end else if (state_reg == WAIT_DONE && !done && timeout_hit) begin
                res_data_reg <= '0;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cmd_ready      = 1'b0;
        wt_ready       = 1'b0;
        wrEn_act_array = 1'b0;
        wrData_act     = '0;
        wrEn_queue     = 1'b0;
        wrData_queue   = '0;
        input_wt       = '0;
        res_valid      = 1'b0;
        res_data       = '0;
        res_err        = '0;
        busy           = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered during reset.
                cmd_ready = !reset;
                if (cmd_valid) state_next = LOAD;
            end
            LOAD: begin
                wrEn_act_array = 1'b1;
                wrData_act     = act_reg;
                wrEn_queue     = 1'b1;
                wrData_queue   = scale_reg;
                state_next     = ALIGN;
            end
            ALIGN: begin
                // Leaving on all-ones puts the first weight on phase 0.
                if (all_ones) state_next = STREAM;
            end
            STREAM: begin
                wt_ready = slot_start;
                input_wt = slot_start ? slot_wt : wt_hold_reg;
                // The counter spans exactly NUM*THRU cycles, so the stream
                // ends on the same all-ones phase that started it.
                if (all_ones) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    state_next = CAPTURE;
                end else if (timeout_hit) begin
                    state_next = RESULT;
                end
            end
            CAPTURE: begin
                state_next = RESULT;
            end
            RESULT: begin
                res_valid              = 1'b1;
                res_data               = res_data_reg;
                res_err[ERR_TIMEOUT]   = timeout_flag;
                res_err[ERR_UNDERRUN]  = underrun_reg;
                if (res_ready) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
